// File: rtl/led_matrix_scan.sv
// led_matrix_scan: row/column multiplex scanner for front-panel lamp matrices.
// Each row slot is BLANK_CYCLES with all lines inactive, followed by
// DWELL_CYCLES with one row driven and its lamp slice on the columns. The slice
// is captured when the row lights, so frame_data may change at any time.
//
// Optional build macro: LED_MATRIX_SCAN_DIM_EN adds a 4-bit brightness input
// that shortens the column-on time within each dwell in 1/16 steps.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   enable       scan enable; low forces blanking and holds row_idx
//   brightness   (LED_MATRIX_SCAN_DIM_EN only) column duty in 16ths, minus one
//   frame_data   lamp image, row r = frame_data[r*COLS +: COLS], 1 = lamp on
//   led_row      row drive lines (registered)
//   led_col      column drive lines (registered)
//   row_idx      row currently in its slot, blank or lit (registered)
//   frame_start  one-cycle pulse on the first lit cycle of row 0 (registered)
module led_matrix_scan #(
    parameter int unsigned ROWS            = 5,
    parameter int unsigned COLS            = 8,
    parameter int unsigned DWELL_CYCLES    = 512,
    parameter int unsigned BLANK_CYCLES    = 16,
    parameter bit          ROW_ACTIVE_HIGH = 1'b1,
    parameter bit          COL_ACTIVE_LOW  = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
`ifdef LED_MATRIX_SCAN_DIM_EN
    input  logic [3:0]               brightness,
`endif
    input  logic [ROWS*COLS-1:0]     frame_data,
    output logic [ROWS-1:0]          led_row,
    output logic [COLS-1:0]          led_col,
    output logic [$clog2(ROWS)-1:0]  row_idx,
    output logic                     frame_start
);

    localparam int unsigned RIW     = $clog2(ROWS);
    localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX);

    localparam logic [ROWS-1:0] ROW_OFF = ROW_ACTIVE_HIGH ? {ROWS{1'b0}} : {ROWS{1'b1}};
    localparam logic [COLS-1:0] COL_OFF = COL_ACTIVE_LOW  ? {COLS{1'b1}} : {COLS{1'b0}};

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RIW-1:0]    row_idx_q, row_idx_d;
    logic [ROWS-1:0]   led_row_q, led_row_d;
    logic [COLS-1:0]   led_col_q, led_col_d;
    logic              frame_start_q, frame_start_d;

    logic [COLS-1:0]   row_slice;
    logic [ROWS-1:0]   row_onehot;
    logic [COLS-1:0]   col_drive;

`ifdef LED_MATRIX_SCAN_DIM_EN
    localparam int unsigned DIM_STEP = DWELL_CYCLES / 16;

    logic [COLS-1:0]   col_lit_q, col_lit_d;
    logic [3:0]        bright_q, bright_d;
    logic              col_on_next;

    // Columns stay lit while the next dwell count is below (brightness+1)/16 of the dwell.
    assign col_on_next = (32'(cnt_q) + 32'd1) < ((32'(bright_q) + 32'd1) * DIM_STEP);
`endif

    // Select the current row's lamp slice and one-hot row pattern.
    always_comb begin
        row_slice  = '0;
        row_onehot = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_idx_q == RIW'(r)) begin
                row_slice     = frame_data[r*COLS +: COLS];
                row_onehot[r] = 1'b1;
            end
        end
    end

    assign col_drive = COL_ACTIVE_LOW ? ~row_slice : row_slice;

    // Next-state and output logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + CW'(1);
        row_idx_d     = row_idx_q;
        led_row_d     = led_row_q;
        led_col_d     = led_col_q;
        frame_start_d = 1'b0;
`ifdef LED_MATRIX_SCAN_DIM_EN
        col_lit_d     = col_lit_q;
        bright_d      = bright_q;
`endif
        if (!enable) begin
            state_d   = ST_BLANK;
            cnt_d     = '0;
            led_row_d = ROW_OFF;
            led_col_d = COL_OFF;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    led_row_d = ROW_OFF;
                    led_col_d = COL_OFF;
                    if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
                        state_d       = ST_ON;
                        cnt_d         = '0;
                        led_row_d     = ROW_ACTIVE_HIGH ? row_onehot : ~row_onehot;
                        led_col_d     = col_drive;
                        frame_start_d = (row_idx_q == '0);
`ifdef LED_MATRIX_SCAN_DIM_EN
                        col_lit_d     = col_drive;
                        bright_d      = brightness;
`endif
                    end
                end
                ST_ON: begin
                    if (cnt_q == CW'(DWELL_CYCLES - 1)) begin
                        state_d   = ST_BLANK;
                        cnt_d     = '0;
                        led_row_d = ROW_OFF;
                        led_col_d = COL_OFF;
                        row_idx_d = (row_idx_q == RIW'(ROWS - 1)) ? '0 : row_idx_q + RIW'(1);
                    end
`ifdef LED_MATRIX_SCAN_DIM_EN
                    else begin
                        led_col_d = col_on_next ? col_lit_q : COL_OFF;
                    end
`endif
                end
                default: begin
                    state_d   = ST_BLANK;
                    cnt_d     = '0;
                    led_row_d = ROW_OFF;
                    led_col_d = COL_OFF;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_BLANK;
            cnt_q         <= '0;
            row_idx_q     <= '0;
            led_row_q     <= ROW_OFF;
            led_col_q     <= COL_OFF;
            frame_start_q <= 1'b0;
`ifdef LED_MATRIX_SCAN_DIM_EN
            col_lit_q     <= COL_OFF;
            bright_q      <= 4'hF;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            row_idx_q     <= row_idx_d;
            led_row_q     <= led_row_d;
            led_col_q     <= led_col_d;
            frame_start_q <= frame_start_d;
`ifdef LED_MATRIX_SCAN_DIM_EN
            col_lit_q     <= col_lit_d;
            bright_q      <= bright_d;
`endif
        end
    end

    assign led_row     = led_row_q;
    assign led_col     = led_col_q;
    assign row_idx     = row_idx_q;
    assign frame_start = frame_start_q;

endmodule
